mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan_if.sv | 22 ++
 rtl/mux_scan.sv | 119 +++++++++++
 tb/tb_mux_scan.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Scan bus between mux_scan and its driver:
// request/config inputs, mux feedback, select and results.
interface mux_scan_if;
   logic       start;
   logic       cont;
   logic [3:0] mask;
   logic       r;
   logic [1:0] s;
   logic [3:0] q;
   logic       busy;
   logic       done;

   modport master (
      output start, cont, mask, r,
      input  s, q, busy, done
   );

   modport slave (
      input  start, cont, mask, r,
      output s, q, busy, done
   );
endinterface

// File: rtl/mux_scan.sv
// Scans enabled channels of an external 4:1 mux, dwelling on each
// select for DWELL cycles, and publishes the captured bits on q.
module mux_scan #(
   parameter int unsigned DWELL = 2
) (
   input logic        clk,
   input logic        rst_n,
   mux_scan_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam logic [3:0] LAST = 4'(DWELL - 1);

   state_e     state_q;
   logic [1:0] s_q;
   logic [3:0] cnt_q;
   logic [3:0] shadow_q;
   logic [3:0] mask_q;
   logic [3:0] q_q;
   logic       busy_q;
   logic       done_q;

   logic [3:0] cap_d;
   logic [2:0] nxt_d;

   function automatic logic [1:0] lowest(
      input logic [3:0] m
   );
      lowest = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) lowest = 2'(i);
      end
   endfunction

   // {found, index} of the next enabled channel above idx
   function automatic logic [2:0] above(
      input logic [3:0] m,
      input logic [1:0] idx
   );
      above = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(idx))) begin
            above = {1'b1, 2'(i)};
         end
      end
   endfunction

   always_comb begin
      cap_d        = shadow_q;
      cap_d[s_q]   = bus.r;
      nxt_d        = above(mask_q, s_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         s_q      <= 2'd0;
         cnt_q    <= 4'd0;
         shadow_q <= 4'd0;
         mask_q   <= 4'd0;
         q_q      <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.mask == 4'd0) begin
                     q_q    <= 4'd0;
                     done_q <= 1'b1;
                  end else begin
                     mask_q   <= bus.mask;
                     shadow_q <= 4'd0;
                     s_q      <= lowest(bus.mask);
                     cnt_q    <= 4'd0;
                     busy_q   <= 1'b1;
                     state_q  <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (cnt_q != LAST) begin
                  cnt_q <= cnt_q + 4'd1;
               end else begin
                  cnt_q <= 4'd0;
                  if (nxt_d[2]) begin
                     s_q      <= nxt_d[1:0];
                     shadow_q <= cap_d;
                  end else begin
                     // final capture: publish including this bit
                     q_q      <= cap_d;
                     done_q   <= 1'b1;
                     shadow_q <= 4'd0;
                     if (bus.cont) begin
                        s_q <= lowest(mask_q);
                     end else begin
                        s_q     <= 2'd0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s    = s_q;
   assign bus.q    = q_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_mux_scan.sv
// Randomised scoreboard bench for mux_scan: expected selects and
// results come from a channel-list model of the scan.
module tb_mux_scan;

   localparam int DW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_scan_if bus ();
   mux_scan_if bus1 ();

   logic [3:0] w;
   logic [3:0] w1;

   assign bus.r  = w[bus.s];
   assign bus1.r = w1[bus1.s];

   mux_scan #(.DWELL(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux_scan #(.DWELL(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      logic [3:0] q;
      int         len;
   } res_t;

   int   tests = 0;
   int   fails = 0;
   int   exp_s[$];
   res_t exp_r[$];

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Model: enabled channels in ascending order, DW cycles each;
   // result is the mux input pattern masked by the channel set.
   task automatic push_scan(
      input  logic [3:0] m,
      input  logic [3:0] wv,
      input  bit         with_q,
      output int         len
   );
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            n++;
            repeat (DW) exp_s.push_back(i);
         end
      end
      len = n * DW;
      if (with_q) exp_r.push_back(res_t'{q: wv & m, len: len});
   endtask

   task automatic run_scan(
      input logic [3:0] m,
      input logic [3:0] wv,
      input bit         noise
   );
      int len;
      @(negedge clk);
      bus.cont  = 1'b0;
      w         = wv;
      bus.start = 1'b1;
      bus.mask  = m;
      push_scan(m, wv, 1'b1, len);
      repeat (len) begin
         @(negedge clk);
         if (noise) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.mask  = 4'($urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Monitor: pops expected selects while busy, results on done.
   int         run_cnt;
   logic [3:0] q_cur;
   res_t       e;

   always @(negedge clk) begin
      if (!rst_n) begin
         run_cnt = 0;
         q_cur   = 4'd0;
      end else begin
         if (bus.done) begin
            if (exp_r.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = exp_r.pop_front();
               chk("q_result", bus.q, e.q);
               chk("scan_len", run_cnt, e.len);
               q_cur = e.q;
            end
            run_cnt = 0;
         end else begin
            chk("q_stable", bus.q, q_cur);
         end
         if (bus.busy) begin
            run_cnt++;
            if (exp_s.size() == 0) begin
               chk("busy_unexpected", 1, 0);
            end else begin
               chk("s_seq", bus.s, exp_s.pop_front());
            end
         end else begin
            chk("s_idle", bus.s, 0);
         end
      end
   end

   initial begin
      int len;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.cont   = 1'b0;
      bus.mask   = 4'd0;
      bus1.start = 1'b0;
      bus1.cont  = 1'b0;
      bus1.mask  = 4'd0;
      w          = 4'd0;
      w1         = 4'd0;
      #1;
      chk("rst_q", bus.q, 0);
      chk("rst_s", bus.s, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_scan(4'b1111, 4'b1010, 1'b0);
      run_scan(4'b0101, 4'b1111, 1'b0);
      run_scan(4'b0000, 4'b1111, 1'b0);
      run_scan(4'b1000, 4'b1000, 1'b1);

      for (int i = 0; i < 14; i++) begin
         run_scan(4'($urandom), 4'($urandom), 1'(i % 2));
      end

      // continuous mode, mux pattern changed between scans
      @(negedge clk);
      w         = 4'b0011;
      bus.cont  = 1'b1;
      bus.start = 1'b1;
      bus.mask  = 4'b1111;
      push_scan(4'b1111, 4'b0011, 1'b1, len);
      push_scan(4'b1111, 4'b1100, 1'b1, len);
      repeat (len) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      @(negedge clk);
      w        = 4'b1100;
      bus.cont = 1'b0;
      repeat (len) @(negedge clk);

      // asynchronous reset during channel 2
      run_scan(4'b1111, 4'b1010, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mask  = 4'b1111;
      push_scan(4'b1111, 4'b1010, 1'b0, len);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_s.delete();
      #1;
      chk("arst_q", bus.q, 0);
      chk("arst_s", bus.s, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      run_scan(4'b0110, 4'b1110, 1'b0);

      // single-cycle dwell instance
      @(negedge clk);
      w1         = 4'($urandom);
      bus1.start = 1'b1;
      bus1.mask  = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus1.start = 1'b0;
         chk("d1_s", bus1.s, i);
         chk("d1_busy", bus1.busy, 1);
      end
      @(negedge clk);
      chk("d1_done", bus1.done, 1);
      chk("d1_q", bus1.q, w1);
      chk("d1_idle", bus1.busy, 0);

      for (int i = 0; i < 40; i++) begin
         if (exp_s.size() != 0 || exp_r.size() != 0) @(negedge clk);
      end
      if (exp_s.size() != 0 || exp_r.size() != 0) begin
         chk("drain_timeout", exp_s.size() + exp_r.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
